// File: rtl/renode_axi_burst_manager.sv
// rtl/renode_axi_burst_manager.sv - single-outstanding AXI4 INCR burst manager; optional ID check via RENODE_AXI_MANAGER_ID_CHECK_EN
module renode_axi_burst_manager #(
  parameter int  AddressWidth       = 32,
  parameter int  DataWidth          = 32,
  parameter int  TransactionIdWidth = 8,
  parameter int  MaxBurstLength     = 16,
  localparam int StrobeWidth        = DataWidth / 8
) (
  input  logic                          clk,
  input  logic                          areset_n,
  // command
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AddressWidth-1:0]       cmd_addr,
  input  logic [7:0]                    cmd_len,
  input  logic [2:0]                    cmd_size,
  input  logic [TransactionIdWidth-1:0] cmd_id,
  // write beat stream
  input  logic [DataWidth-1:0]          wr_data,
  input  logic [StrobeWidth-1:0]        wr_strb,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  // read beat stream
  output logic [DataWidth-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          rd_last,
  // completion
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_error,
  output logic [1:0]                    resp_code,
  // AXI AW
  output logic [TransactionIdWidth-1:0] awid,
  output logic [AddressWidth-1:0]       awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic                          awlock,
  output logic [2:0]                    awprot,
  output logic                          awvalid,
  input  logic                          awready,
  // AXI W
  output logic [DataWidth-1:0]          wdata,
  output logic [StrobeWidth-1:0]        wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  // AXI B
  input  logic [TransactionIdWidth-1:0] bid,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  // AXI AR
  output logic [TransactionIdWidth-1:0] arid,
  output logic [AddressWidth-1:0]       araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arlock,
  output logic [2:0]                    arprot,
  output logic                          arvalid,
  input  logic                          arready,
  // AXI R
  input  logic [TransactionIdWidth-1:0] rid,
  input  logic [DataWidth-1:0]          rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, WRESP, READ, DONE} state_t;

  localparam logic [2:0] SizeMax  = 3'($clog2(StrobeWidth));
  localparam logic [8:0] MaxBeats = 9'(MaxBurstLength);

  state_t                        state_q, state_d;
  logic                          cmd_ready_q;
  logic                          write_q;
  logic [AddressWidth-1:0]       addr_q;
  logic [7:0]                    len_q;
  logic [2:0]                    size_q;
  logic [TransactionIdWidth-1:0] id_q;
  logic                          awvalid_q, arvalid_q;
  logic                          aw_done_q, w_done_q, b_done_q;
  logic [8:0]                    beat_cnt_q;
  logic [1:0]                    code_q;
  logic                          proto_err_q;

  logic        cmd_fire, aw_fire, ar_fire, w_active, w_fire, w_last_fire;
  logic        b_fire, r_fire, at_len, bready_int;
  logic        aw_complete, w_complete, b_complete;
  logic        b_id_err, r_id_err;
  logic        reject;
  logic [7:0]  align_mask;
  logic [16:0] burst_bytes, burst_end;

  assign at_len      = (beat_cnt_q == {1'b0, len_q});
  assign cmd_fire    = (state_q == IDLE) && cmd_ready_q && cmd_valid;
  assign aw_fire     = awvalid_q && awready;
  assign ar_fire     = arvalid_q && arready;
  assign w_active    = (state_q == WRITE) && !w_done_q;
  assign w_fire      = w_active && wr_valid && wready;
  assign w_last_fire = w_fire && at_len;
  assign aw_complete = aw_done_q || aw_fire;
  assign w_complete  = w_done_q || w_last_fire;
  // B is only taken once the W side is finished, including the cycle of the last W beat
  assign bready_int  = (state_q == WRESP) || ((state_q == WRITE) && w_complete);
  assign b_fire      = bvalid && bready_int;
  assign b_complete  = b_done_q || b_fire;
  assign r_fire      = (state_q == READ) && rvalid && rd_ready;

`ifdef RENODE_AXI_MANAGER_ID_CHECK_EN
  assign b_id_err = (bid != id_q);
  assign r_id_err = (rid != id_q);
`else
  logic unused_ids;
  assign unused_ids = ^{bid, rid};
  assign b_id_err   = 1'b0;
  assign r_id_err   = 1'b0;
`endif

  // legality of the latched command: size, alignment, beat count, 4 KiB crossing
  always_comb begin
    align_mask  = (8'd1 << size_q) - 8'd1;
    burst_bytes = ({9'd0, len_q} + 17'd1) << size_q;
    burst_end   = {5'd0, addr_q[11:0]} + burst_bytes;
    reject      = (size_q > SizeMax)
               || ((addr_q[7:0] & align_mask) != 8'd0)
               || (({1'b0, len_q} + 9'd1) > MaxBeats)
               || (burst_end > 17'd4096);
  end

  // state register
  always_ff @(posedge clk) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = CHECK;
      CHECK:   state_d = reject ? DONE : (write_q ? WRITE : READ);
      WRITE:   if (aw_complete && w_complete) state_d = b_complete ? DONE : WRESP;
      WRESP:   if (bvalid) state_d = DONE;
      READ:    if (r_fire && rlast) state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // command latch, AXI address valids, beat counting and response aggregation
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      cmd_ready_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      id_q        <= '0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      beat_cnt_q  <= '0;
      code_q      <= 2'b00;
      proto_err_q <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == IDLE);
      if (cmd_fire) begin
        write_q     <= cmd_write;
        addr_q      <= cmd_addr;
        len_q       <= cmd_len;
        size_q      <= cmd_size;
        id_q        <= cmd_id;
        aw_done_q   <= 1'b0;
        w_done_q    <= 1'b0;
        b_done_q    <= 1'b0;
        beat_cnt_q  <= '0;
        code_q      <= 2'b00;
        proto_err_q <= 1'b0;
      end
      if (state_q == CHECK) begin
        if (reject)       code_q    <= 2'b10;
        else if (write_q) awvalid_q <= 1'b1;
        else              arvalid_q <= 1'b1;
      end
      if (aw_fire) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (ar_fire) arvalid_q <= 1'b0;
      // saturate so stray beats past len can never wrap back onto len
      if ((w_fire || r_fire) && (beat_cnt_q != 9'h1FF)) beat_cnt_q <= beat_cnt_q + 9'd1;
      if (w_last_fire) w_done_q <= 1'b1;
      if (b_fire) begin
        b_done_q <= 1'b1;
        if (bresp > code_q) code_q <= bresp;
        if (b_id_err) proto_err_q <= 1'b1;
      end
      if (r_fire) begin
        if (rresp > code_q) code_q <= rresp;
        if (rlast != at_len) proto_err_q <= 1'b1;
        if (r_id_err) proto_err_q <= 1'b1;
      end
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign resp_valid = (state_q == DONE);
  assign resp_code  = code_q;
  assign resp_error = code_q[1] || proto_err_q;

  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;

  assign wdata    = wr_data;
  assign wstrb    = wr_strb;
  assign wvalid   = w_active && wr_valid;
  assign wr_ready = w_active && wready;
  assign wlast    = w_active && at_len;
  assign bready   = bready_int;

  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;

  assign rready   = (state_q == READ) && rd_ready;
  assign rd_valid = (state_q == READ) && rvalid;
  assign rd_data  = rdata;
  assign rd_last  = (state_q == READ) && rlast;

endmodule
